// File: rtl/freq_divider_unit.sv
// ---------------------------------------------------------------------------
// freq_divider_unit
//
// Measures the period of a slow external waveform (InFreq) in RefClk cycles,
// then generates OutFreq with period = measured period * 2^n at 50 % duty.
// A measurement is started by pressing and releasing `adjust`; once locked
// the output runs on its own until the next adjust or reset.
//
// Ports
//   RefClk    in   reference clock, rising edge
//   rst       in   asynchronous active-high reset
//   InFreq    in   asynchronous input waveform (only rising edges matter)
//   adjust    in   measurement request, acted on at its falling edge
//   n         in   division exponent, sampled once per measurement
//   OutFreq   out  divided output clock, straight from a flop
//   done      out  high while locked and generating
//   period    out  last measured input period in RefClk cycles
//   overflow  out  half-period saturated at the last calculation (sticky)
//   timeout   out  last measurement saw no second edge (sticky)
// ---------------------------------------------------------------------------
module freq_divider_unit #(
   parameter int CNT_W  = 16,
   parameter int HALF_W = 20
) (
   input  logic              RefClk,
   input  logic              rst,
   input  logic              InFreq,
   input  logic              adjust,
   input  logic [2:0]        n,
   output logic              OutFreq,
   output logic              done,
   output logic [CNT_W-1:0]  period,
   output logic              overflow,
   output logic              timeout
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARM     = 3'd1;
   localparam logic [2:0] SYNC    = 3'd2;
   localparam logic [2:0] MEASURE = 3'd3;
   localparam logic [2:0] CALC    = 3'd4;
   localparam logic [2:0] RUN     = 3'd5;

   // Product width leaves room for a shift by up to 7; the comparison width
   // is kept at least one bit wider than the half-period so saturation can
   // be detected for any parameter combination.
   localparam int PW = CNT_W + 7;
   localparam int CW = (PW > HALF_W) ? PW : HALF_W + 1;
   localparam logic [CW-1:0]    HALF_MAX = {{(CW-HALF_W){1'b0}}, {HALF_W{1'b1}}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [2:0]        state_reg;
   logic              sync1_reg, sync2_reg, sync3_reg;
   logic              rise_pulse;
   logic [CNT_W-1:0]  cnt_reg;
   logic [HALF_W-1:0] half_reg;
   logic [HALF_W-1:0] gen_cnt_reg;

   logic [PW-1:0]     prod;
   logic [CW-1:0]     half_wide;
   logic              half_sat;
   logic [HALF_W-1:0] half_next;

   assign rise_pulse = sync2_reg & ~sync3_reg;

   // Half-period derived from the freshly measured period; only consumed in
   // CALC, where `period` already holds the new measurement.
   always_comb begin
      prod      = PW'(period) << n;
      half_wide = CW'(prod >> 1);
      half_sat  = (half_wide > HALF_MAX);
      half_next = half_sat ? HALF_MAX[HALF_W-1:0] : half_wide[HALF_W-1:0];
      if (half_next == '0)
         half_next = HALF_W'(1);
   end

   always_ff @(posedge RefClk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         sync3_reg   <= 1'b0;
         cnt_reg     <= '0;
         half_reg    <= '0;
         gen_cnt_reg <= '0;
         OutFreq     <= 1'b0;
         done        <= 1'b0;
         period      <= '0;
         overflow    <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         sync1_reg <= InFreq;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;

         case (state_reg)
            IDLE: begin
               OutFreq <= 1'b0;
               if (adjust)
                  state_reg <= ARM;
            end
            ARM: begin
               timeout  <= 1'b0;
               overflow <= 1'b0;
               done     <= 1'b0;
               OutFreq  <= 1'b0;
               if (!adjust)
                  state_reg <= SYNC;
            end
            SYNC: begin
               if (rise_pulse) begin
                  cnt_reg   <= '0;
                  state_reg <= MEASURE;
               end
            end
            MEASURE: begin
               // cnt holds (cycles since the first edge) - 1, so cnt+1 is
               // the edge-to-edge distance.
               if (rise_pulse) begin
                  period    <= cnt_reg + CNT_W'(1);
                  state_reg <= CALC;
               end else if (cnt_reg == CNT_MAX) begin
                  timeout   <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            CALC: begin
               half_reg    <= half_next;
               if (half_sat)
                  overflow <= 1'b1;
               gen_cnt_reg <= '0;
               OutFreq     <= 1'b0;
               done        <= 1'b1;
               state_reg   <= RUN;
            end
            RUN: begin
               if (adjust) begin
                  OutFreq     <= 1'b0;
                  done        <= 1'b0;
                  gen_cnt_reg <= '0;
                  state_reg   <= ARM;
               end else if (gen_cnt_reg == half_reg - HALF_W'(1)) begin
                  OutFreq     <= ~OutFreq;
                  gen_cnt_reg <= '0;
               end else begin
                  gen_cnt_reg <= gen_cnt_reg + HALF_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_divider_unit.sv
// ---------------------------------------------------------------------------
// tb_freq_divider_unit
//
// Directed and randomized checks of freq_divider_unit. The unit is built
// with narrow counters so timeout and saturation are reachable quickly.
// Expected values come from the arithmetic definition of the block:
// period = input period, half = clamp(max(1, (P << n) >> 1)), and OutFreq
// rising `half` cycles after lock, then spending `half` cycles per level.
// ---------------------------------------------------------------------------
module tb_freq_divider_unit;

   localparam int TCW  = 10;
   localparam int THW  = 12;
   localparam int HMAX = (1 << THW) - 1;

   logic           RefClk = 1'b0;
   logic           rst;
   logic           InFreq = 1'b0;
   logic           adjust;
   logic [2:0]     n;
   logic           OutFreq;
   logic           done;
   logic [TCW-1:0] period;
   logic           overflow;
   logic           timeout;

   int errors = 0;
   int checks = 0;
   int in_per = 0;
   int cur_per = 0;
   int ph = 0;
   int model_period = 0;

   freq_divider_unit #(.CNT_W(TCW), .HALF_W(THW)) dut (
      .RefClk   (RefClk),
      .rst      (rst),
      .InFreq   (InFreq),
      .adjust   (adjust),
      .n        (n),
      .OutFreq  (OutFreq),
      .done     (done),
      .period   (period),
      .overflow (overflow),
      .timeout  (timeout)
   );

   always #5 RefClk = ~RefClk;

   // Input waveform: period in_per cycles, restarting its phase whenever the
   // period is changed so every edge after a change is spaced by in_per.
   always @(negedge RefClk) begin
      if (in_per != cur_per) begin
         cur_per = in_per;
         ph = 0;
      end
      if (cur_per <= 0) begin
         InFreq = 1'b0;
      end else begin
         InFreq = (ph < cur_per / 2);
         ph = (ph + 1 >= cur_per) ? 0 : ph + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic int exp_half(input int p, input int nn);
      longint h;
      h = (longint'(p) << nn) >> 1;
      if (h > HMAX) h = HMAX;
      if (h == 0) h = 1;
      return int'(h);
   endfunction

   function automatic int exp_ovf(input int p, input int nn);
      longint h;
      h = (longint'(p) << nn) >> 1;
      return (h > HMAX) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < budget) begin
         @(negedge RefClk);
         cyc++;
      end
   endtask

   task automatic wait_out(input logic v, input int budget, output int cyc);
      cyc = 0;
      while (OutFreq !== v && cyc < budget) begin
         @(negedge RefClk);
         cyc++;
      end
   endtask

   task automatic press_adjust(input string tag);
      adjust = 1'b1;
      @(negedge RefClk);
      check({tag, "_done_drop"}, done, 0);
      check({tag, "_out_forced0"}, OutFreq, 0);
      repeat (3) @(negedge RefClk);
      adjust = 1'b0;
   endtask

   task automatic lock(input string tag, input int p, input int nn);
      int c;
      int h;
      in_per = p;
      n = 3'(nn);
      press_adjust(tag);
      wait_done(4 * p + 40, c);
      check({tag, "_done"}, done, 1);
      h = exp_half(p, nn);
      model_period = p;
      check({tag, "_period"}, period, p);
      check({tag, "_overflow"}, overflow, exp_ovf(p, nn));
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_out_at_lock"}, OutFreq, 0);
      // n is only sampled during the calculation; disturbing it now must
      // not change the running output.
      n = 3'($urandom);
      wait_out(1'b1, h + 5, c);
      check({tag, "_first_rise"}, c, h);
      wait_out(1'b0, h + 5, c);
      check({tag, "_high_len"}, c, h);
      if (h < 2000) begin
         wait_out(1'b1, h + 5, c);
         check({tag, "_low_len"}, c, h);
      end
      $display("lock %s: P=%0d n=%0d half=%0d period=%0d ovf=%0d", tag, p, nn, h, period, overflow);
   endtask

   initial begin
      int c;
      rst = 1'b1;
      adjust = 1'b0;
      n = 3'd0;
      repeat (3) @(negedge RefClk);
      check("rst_out", OutFreq, 0);
      check("rst_done", done, 0);
      check("rst_period", period, 0);
      check("rst_overflow", overflow, 0);
      check("rst_timeout", timeout, 0);
      rst = 1'b0;
      repeat (5) @(negedge RefClk);
      check("idle_done", done, 0);

      lock("p10_n0", 10, 0);
      lock("p10_n3", 10, 3);
      lock("p2_n0", 2, 0);
      lock("ovf_p100_n7", 100, 7);

      // Input period longer than the counter range: one edge starts the
      // measurement, the counter runs out before the next one.
      in_per = 3000;
      press_adjust("tmo");
      check("tmo_ovf_cleared", overflow, 0);
      c = 0;
      while (timeout !== 1'b1 && c < 6000) begin
         @(negedge RefClk);
         c++;
      end
      check("tmo_timeout", timeout, 1);
      check("tmo_done", done, 0);
      check("tmo_out", OutFreq, 0);
      check("tmo_period_kept", period, model_period);
      repeat (20) @(negedge RefClk);
      check("tmo_idle_out", OutFreq, 0);
      $display("timeout: flagged after %0d cycles, period kept %0d", c, period);

      lock("rl_p10_n1", 10, 1);
      lock("rl_p30_n1", 30, 1);

      for (int t = 0; t < 4; t++) begin
         lock("rnd", int'($urandom_range(60, 2)), int'($urandom_range(5, 0)));
      end

      // Asynchronous reset while the output is high.
      lock("pre_rst", 8, 2);
      wait_out(1'b1, exp_half(8, 2) + 5, c);
      check("pre_rst_high", OutFreq, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_out", OutFreq, 0);
      check("arst_done", done, 0);
      check("arst_period", period, 0);
      check("arst_overflow", overflow, 0);
      check("arst_timeout", timeout, 0);
      @(negedge RefClk);
      rst = 1'b0;
      repeat (50) @(negedge RefClk);
      check("post_rst_done", done, 0);
      check("post_rst_out", OutFreq, 0);
      $display("reset mid-RUN: outputs cleared, idle for 50 cycles");

      lock("after_rst", 12, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
